// File: rtl/dp_ram_bytewe_pipe_if.sv
// Request/response bundle for dp_ram_bytewe_pipe: two independent byte-enabled
// ports plus clear/collision status. The master side issues requests.
interface dp_ram_bytewe_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_WIDTH = 8
);
    localparam int NB = DATA_WIDTH / BYTE_WIDTH;

    logic                  en_a;
    logic [NB-1:0]         we_a;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [DATA_WIDTH-1:0] din_a;
    logic [DATA_WIDTH-1:0] dout_a;
    logic                  dout_valid_a;
    logic                  parity_err_a;

    logic                  en_b;
    logic [NB-1:0]         we_b;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] din_b;
    logic [DATA_WIDTH-1:0] dout_b;
    logic                  dout_valid_b;
    logic                  parity_err_b;

    logic                  busy;
    logic                  collision;

    modport master (
        output en_a, we_a, addr_a, din_a, en_b, we_b, addr_b, din_b,
        input  dout_a, dout_valid_a, parity_err_a,
        input  dout_b, dout_valid_b, parity_err_b,
        input  busy, collision
    );

    modport slave (
        input  en_a, we_a, addr_a, din_a, en_b, we_b, addr_b, din_b,
        output dout_a, dout_valid_a, parity_err_a,
        output dout_b, dout_valid_b, parity_err_b,
        output busy, collision
    );
endinterface

// File: rtl/dp_ram_bytewe_pipe.sv
// True dual-port byte-write RAM with pipelined reads, post-reset clear sequencer and
// write-collision flag. Define DPRAM_PARITY_EN to store and check per-byte even parity.
module dp_ram_bytewe_pipe #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int BYTE_WIDTH     = 8,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input logic                  clk,
    input logic                  rst,
    dp_ram_bytewe_pipe_if.slave  bus
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int RL    = READ_LATENCY;

    typedef enum logic [1:0] {S_RESET, S_CLEAR, S_READY} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  clr_we;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  en       [2];
    logic [NB-1:0]         we       [2];
    logic [ADDR_WIDTH-1:0] addr     [2];
    logic [DATA_WIDTH-1:0] din      [2];
    logic                  acc      [2];
    logic                  wr       [2];
    logic [DATA_WIDTH-1:0] old_word [2];
    logic [DATA_WIDTH-1:0] rd_word  [2];

    logic [RL-1:0]         vld_q [2], vld_d [2];
    logic [DATA_WIDTH-1:0] dat_q [2][RL], dat_d [2][RL];
    logic                  collision_q, collision_d;

`ifdef DPRAM_PARITY_EN
    logic [NB-1:0]         par_mem [DEPTH];
    logic                  perr_raw [2];
    logic [RL-1:0]         perr_q [2], perr_d [2];

    function automatic logic [NB-1:0] byte_par(input logic [DATA_WIDTH-1:0] w);
        logic [NB-1:0] p;
        for (int unsigned i = 0; i < NB; i++) p[i] = ^w[i*BYTE_WIDTH +: BYTE_WIDTH];
        return p;
    endfunction
`endif

    assign en[0]   = bus.en_a;   assign en[1]   = bus.en_b;
    assign we[0]   = bus.we_a;   assign we[1]   = bus.we_b;
    assign addr[0] = bus.addr_a; assign addr[1] = bus.addr_b;
    assign din[0]  = bus.din_a;  assign din[1]  = bus.din_b;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            S_RESET: begin
                cnt_d   = '0;
                state_d = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;
            end
            S_CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = S_READY;
            end
            S_READY: ;
            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            acc[p]      = en[p] && (state_q == S_READY) && !rst;
            wr[p]       = acc[p] && (we[p] != '0);
            old_word[p] = mem[addr[p]];
            rd_word[p]  = old_word[p];
            for (int unsigned i = 0; i < NB; i++)
                if (RDW_MODE == 0 && we[p][i])
                    rd_word[p][i*BYTE_WIDTH +: BYTE_WIDTH] = din[p][i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef DPRAM_PARITY_EN
            perr_raw[p] = (RDW_MODE == 0 && we[p] != '0) ? 1'b0
                        : (byte_par(old_word[p]) != par_mem[addr[p]]);
`endif
        end
        collision_d = wr[0] && wr[1] && (addr[0] == addr[1]) && ((we[0] & we[1]) != '0);
    end

    // Data stages load only behind a valid, so the last stage holds between pulses.
    always_comb begin
        for (int unsigned p = 0; p < 2; p++) begin
            vld_d[p][0] = acc[p];
            dat_d[p][0] = acc[p] ? rd_word[p] : dat_q[p][0];
`ifdef DPRAM_PARITY_EN
            perr_d[p][0] = acc[p] && perr_raw[p];
`endif
            for (int unsigned s = 1; s < RL; s++) begin
                vld_d[p][s] = vld_q[p][s-1];
                dat_d[p][s] = vld_q[p][s-1] ? dat_q[p][s-1] : dat_q[p][s];
`ifdef DPRAM_PARITY_EN
                perr_d[p][s] = vld_q[p][s-1] && perr_q[p][s-1];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            collision_q <= 1'b0;
            for (int unsigned p = 0; p < 2; p++) begin
                vld_q[p] <= '0;
`ifdef DPRAM_PARITY_EN
                perr_q[p] <= '0;
`endif
                for (int unsigned s = 0; s < RL; s++) dat_q[p][s] <= '0;
            end
        end else begin
            collision_q <= collision_d;
            for (int unsigned p = 0; p < 2; p++) begin
                vld_q[p] <= vld_d[p];
`ifdef DPRAM_PARITY_EN
                perr_q[p] <= perr_d[p];
`endif
                for (int unsigned s = 0; s < RL; s++) dat_q[p][s] <= dat_d[p][s];
            end
        end
    end

    // Port B is written first so port A's later assignment wins overlapping bytes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem[cnt_q] <= '0;
`ifdef DPRAM_PARITY_EN
                par_mem[cnt_q] <= '0;
`endif
            end
            for (int unsigned q = 0; q < 2; q++)
                for (int unsigned i = 0; i < NB; i++)
                    if (wr[1-q] && we[1-q][i]) begin
                        mem[addr[1-q]][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[1-q][i*BYTE_WIDTH +: BYTE_WIDTH];
`ifdef DPRAM_PARITY_EN
                        par_mem[addr[1-q]][i] <= ^din[1-q][i*BYTE_WIDTH +: BYTE_WIDTH];
`endif
                    end
        end
    end

    assign bus.dout_a       = dat_q[0][RL-1];
    assign bus.dout_valid_a = vld_q[0][RL-1];
    assign bus.dout_b       = dat_q[1][RL-1];
    assign bus.dout_valid_b = vld_q[1][RL-1];
    assign bus.busy         = rst || (state_q != S_READY);
    assign bus.collision    = collision_q;
`ifdef DPRAM_PARITY_EN
    assign bus.parity_err_a = perr_q[0][RL-1];
    assign bus.parity_err_b = perr_q[1][RL-1];
`else
    assign bus.parity_err_a = 1'b0;
    assign bus.parity_err_b = 1'b0;
`endif
endmodule

// File: tb/tb_dp_ram_bytewe_pipe.sv
// Directed bench: three RAM instances (latency 1/2/3, read-first on the latency-2 one)
// share one stimulus stream; expected words are hand-computed per RDW mode.
module tb_dp_ram_bytewe_pipe;
    localparam int DW = 32, AW = 4, BW = 8, NDUT = 3;

    typedef struct {
        logic        en_a;  logic [3:0] we_a; logic [3:0] addr_a; logic [31:0] din_a;
        logic        en_b;  logic [3:0] we_b; logic [3:0] addr_b; logic [31:0] din_b;
        logic [31:0] xa_wf; logic [31:0] xa_rf;
        logic [31:0] xb_wf; logic [31:0] xb_rf;
        logic        coll;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_a = 1'b0, en_b = 1'b0;
    logic [3:0]  we_a = '0, we_b = '0, addr_a = '0, addr_b = '0;
    logic [31:0] din_a = '0, din_b = '0;

    logic [DW-1:0]   dout_w [NDUT][2];
    logic            vld_w  [NDUT][2];
    logic            perr_w [NDUT][2];
    logic [NDUT-1:0] busy_w, coll_w;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        dp_ram_bytewe_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) bif ();
        assign bif.en_a = en_a; assign bif.we_a = we_a; assign bif.addr_a = addr_a; assign bif.din_a = din_a;
        assign bif.en_b = en_b; assign bif.we_b = we_b; assign bif.addr_b = addr_b; assign bif.din_b = din_b;
        dp_ram_bytewe_pipe #(
            .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW),
            .READ_LATENCY(g + 1), .RDW_MODE((g == 1) ? 1 : 0), .CLEAR_ON_RESET(1)
        ) u_dut (.clk(clk), .rst(rst), .bus(bif));
        assign dout_w[g][0] = bif.dout_a; assign vld_w[g][0] = bif.dout_valid_a; assign perr_w[g][0] = bif.parity_err_a;
        assign dout_w[g][1] = bif.dout_b; assign vld_w[g][1] = bif.dout_valid_b; assign perr_w[g][1] = bif.parity_err_b;
        assign busy_w[g] = bif.busy;
        assign coll_w[g] = bif.collision;
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0;
    logic chk_en = 1'b0;

    // Expected-response rings, one per (instance, port): index k*2+p.
    logic [31:0] exp_data [6][64];
    int unsigned exp_due  [6][64];
    int unsigned head [6], tail [6];
    logic [31:0] last [6];
    logic        coll_exp [1024];

    vec_t vt [48];
    int   nv = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
        end
    endtask

    task automatic flush();
        for (int i = 0; i < 6; i++) begin head[i] = 0; tail[i] = 0; last[i] = '0; end
    endtask

    always @(negedge clk) begin
        int  i;
        logic ev;
        if (chk_en && !rst) begin
            for (int k = 0; k < NDUT; k++) begin
                for (int p = 0; p < 2; p++) begin
                    i  = k * 2 + p;
                    ev = (head[i] != tail[i]) && (exp_due[i][head[i] % 64] == cyc);
                    check($sformatf("valid d%0d p%0d", k, p), 32'(vld_w[k][p]), 32'(ev));
                    if (ev) begin
                        if (vld_w[k][p]) begin
                            check($sformatf("data d%0d p%0d", k, p), dout_w[k][p], exp_data[i][head[i] % 64]);
                            check($sformatf("perr d%0d p%0d", k, p), 32'(perr_w[k][p]), 32'd0);
                            last[i] = exp_data[i][head[i] % 64];
                        end
                        head[i]++;
                    end else if (!vld_w[k][p]) begin
                        check($sformatf("hold d%0d p%0d", k, p), dout_w[k][p], last[i]);
                    end
                end
                check($sformatf("collision d%0d", k), 32'(coll_w[k]), 32'(coll_exp[cyc % 1024]));
            end
        end
    end

    task automatic add(input logic ea, input logic [3:0] wa, input logic [3:0] aa, input logic [31:0] da,
                       input logic eb, input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] db,
                       input logic [31:0] xawf, input logic [31:0] xarf,
                       input logic [31:0] xbwf, input logic [31:0] xbrf, input logic c);
        vt[nv] = '{ea, wa, aa, da, eb, wb, ab, db, xawf, xarf, xbwf, xbrf, c};
        nv++;
    endtask

    task automatic push(input int i, input int k, input logic [31:0] wf, input logic [31:0] rf);
        exp_due[i][tail[i] % 64]  = cyc + k + 1;
        exp_data[i][tail[i] % 64] = (k == 1) ? rf : wf;
        tail[i]++;
    endtask

    task automatic apply(input vec_t v);
        @(posedge clk); #1;
        en_a = v.en_a; we_a = v.we_a; addr_a = v.addr_a; din_a = v.din_a;
        en_b = v.en_b; we_b = v.we_b; addr_b = v.addr_b; din_b = v.din_b;
        for (int k = 0; k < NDUT; k++) begin
            if (v.en_a) push(k * 2,     k, v.xa_wf, v.xa_rf);
            if (v.en_b) push(k * 2 + 1, k, v.xb_wf, v.xb_rf);
        end
        if (v.coll) coll_exp[(cyc + 1) % 1024] = 1'b1;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        en_a = 1'b0; en_b = 1'b0; we_a = '0; we_b = '0;
    endtask

    task automatic reset_values(input string tag);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("%s dout_a d%0d", tag, k), dout_w[k][0], 32'd0);
            check($sformatf("%s dout_b d%0d", tag, k), dout_w[k][1], 32'd0);
            check($sformatf("%s valid d%0d", tag, k), {30'd0, vld_w[k][1], vld_w[k][0]}, 32'd0);
            check($sformatf("%s coll d%0d", tag, k), 32'(coll_w[k]), 32'd0);
            check($sformatf("%s busy d%0d", tag, k), 32'(busy_w[k]), 32'd1);
        end
    endtask

    // Call right after rst is released; cycles are counted from the first edge that sees rst low.
    // A held write to address 0 during the clear must be dropped.
    task automatic busy_phase(input int unsigned exp_n, input string tag);
        int unsigned n [NDUT];
        for (int k = 0; k < NDUT; k++) n[k] = 0;
        en_a = 1'b1; we_a = 4'hF; addr_a = 4'd0; din_a = 32'hFFFF_FFFF;
        en_b = 1'b1; we_b = 4'h0; addr_b = 4'd5;
        @(posedge clk); #1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy_w == '0) break;
            for (int k = 0; k < NDUT; k++) if (busy_w[k]) n[k]++;
        end
        en_a = 1'b0; en_b = 1'b0; we_a = '0;
        for (int k = 0; k < NDUT; k++)
            check($sformatf("%s busy_cycles d%0d", tag, k), n[k], exp_n);
    endtask

    initial begin
        int nmain;
        for (int i = 0; i < 1024; i++) coll_exp[i] = 1'b0;
        flush();

        for (int i = 0; i < 16; i++)
            add(1, 4'h0, 4'(i), '0, 1, 4'h0, 4'(15 - i), '0, '0, '0, '0, '0, 0);
        add(1, 4'hF, 4'd5, 32'hDEADBEEF, 1, 4'h0, 4'd5, '0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 0);
        add(1, 4'h1, 4'd5, 32'h000000AA, 0, 4'h0, 4'd0, '0, 32'hDEADBEAA, 32'hDEADBEEF, '0, '0, 0);
        add(1, 4'h0, 4'd5, '0, 1, 4'h0, 4'd5, '0, 32'hDEADBEAA, 32'hDEADBEAA, 32'hDEADBEAA, 32'hDEADBEAA, 0);
        add(1, 4'hF, 4'd7, 32'hCAFEF00D, 0, 4'h0, 4'd0, '0, 32'hCAFEF00D, 32'h0, '0, '0, 0);
        add(1, 4'hF, 4'd7, 32'h11223344, 1, 4'h0, 4'd7, '0, 32'h11223344, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 0);
        add(1, 4'h0, 4'd7, '0, 1, 4'h0, 4'd7, '0, 32'h11223344, 32'h11223344, 32'h11223344, 32'h11223344, 0);
        add(1, 4'h3, 4'd3, 32'hAAAAAAAA, 1, 4'h6, 4'd3, 32'hBBBBBBBB, 32'h0000AAAA, 32'h0, 32'h00BBBB00, 32'h0, 1);
        add(1, 4'h0, 4'd3, '0, 1, 4'h0, 4'd3, '0, 32'h00BBAAAA, 32'h00BBAAAA, 32'h00BBAAAA, 32'h00BBAAAA, 0);
        add(1, 4'h8, 4'd15, 32'h12345678, 1, 4'h1, 4'd0, 32'h9ABCDEF0, 32'h12000000, 32'h0, 32'h000000F0, 32'h0, 0);
        add(1, 4'h1, 4'd9, 32'h11111111, 1, 4'h8, 4'd9, 32'h22222222, 32'h00000011, 32'h0, 32'h22000000, 32'h0, 0);
        add(0, 4'h0, 4'd0, '0, 0, 4'h0, 4'd0, '0, '0, '0, '0, '0, 0);
        add(1, 4'h0, 4'd15, '0, 1, 4'h0, 4'd0, '0, 32'h12000000, 32'h12000000, 32'h000000F0, 32'h000000F0, 0);
        add(1, 4'h0, 4'd9, '0, 1, 4'h0, 4'd9, '0, 32'h22000011, 32'h22000011, 32'h22000011, 32'h22000011, 0);
        add(1, 4'h0, 4'd9, '0, 1, 4'hF, 4'd9, 32'h55555555, 32'h22000011, 32'h22000011, 32'h55555555, 32'h22000011, 0);
        add(1, 4'h0, 4'd9, '0, 1, 4'h0, 4'd9, '0, 32'h55555555, 32'h55555555, 32'h55555555, 32'h55555555, 0);
        nmain = nv;
        add(1, 4'h0, 4'd0, '0, 1, 4'h0, 4'd5, '0, '0, '0, '0, '0, 0);
        add(1, 4'h0, 4'd9, '0, 1, 4'h0, 4'd3, '0, '0, '0, '0, '0, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_values("por");
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        busy_phase(16, "clear");

        for (int v = 0; v < nmain; v++) apply(vt[v]);
        idle();
        repeat (5) @(posedge clk);

        // Interrupt the clear after six cycles; it must restart from address 0.
        #1 rst = 1'b1;
        flush();
        @(posedge clk); #1;
        rst = 1'b0;
        en_a = 1'b1; we_a = 4'hF; addr_a = 4'd0; din_a = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("midclear busy c%0d", c), 32'(busy_w), 32'(3'b111));
        end
        @(posedge clk); #1;
        rst = 1'b1;
        en_a = 1'b0; we_a = '0;
        @(negedge clk);
        reset_values("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        busy_phase(16, "reclear");

        for (int v = nmain; v < nv; v++) apply(vt[v]);
        idle();
        repeat (6) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dp_ram_bytewe_pipe.md
Name: dp_ram_bytewe_pipe

Overview:
Synthesizable single-clock true dual-port RAM with per-byte write enables, a configurable read-pipeline depth and a selectable read-during-write mode. A reset-triggered clear sequencer zeroes the array, and a collision detector flags same-address writes from both ports. This block backs activation and weight buffers in the accelerator datapath and replaces the simulation-only dual-port model.

Parameters:
DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH
ADDR_WIDTH, 10, address bits; depth = 2**ADDR_WIDTH
BYTE_WIDTH, 8, bits per write-enable lane; NB = DATA_WIDTH/BYTE_WIDTH
READ_LATENCY, 1, cycles from accepted request to dout_valid; legal values 1..3
RDW_MODE, 0, same-port read-during-write: 0 = write-first (new data), 1 = read-first (old data)
CLEAR_ON_RESET, 1, 1 = zero the whole array after reset; 0 = no clear

Ports:
clk  in  1  single clock, all logic on the rising edge
rst  in  1  synchronous, active-high reset
en_a  in  1  port A request
we_a  in  NB  port A byte write enables; all zero = read
addr_a  in  ADDR_WIDTH  port A address
din_a  in  DATA_WIDTH  port A write data
dout_a  out  DATA_WIDTH  port A read data
dout_valid_a  out  1  port A data valid pulse
en_b, we_b, addr_b, din_b, dout_b, dout_valid_b: same as port A, for port B
busy  out  1  clear in progress; requests ignored
collision  out  1  single-cycle pulse: both ports wrote the same address with overlapping byte enables
parity_err_a  out  1  port A parity error, aligned with dout_valid_a (DPRAM_PARITY_EN only)
parity_err_b  out  1  port B parity error, aligned with dout_valid_b (DPRAM_PARITY_EN only)

Behaviour:
- Reset values: dout_a/b = 0, dout_valid_a/b = 0, collision = 0, parity_err_a/b = 0, all pipeline stages cleared. busy = 1 while rst is high.
- Clear FSM has three states: RESET, CLEAR, READY.
  - rst forces RESET on every cycle, including mid-CLEAR; the clear counter returns to 0.
  - After rst is released: go to CLEAR if CLEAR_ON_RESET=1, else go to READY.
  - CLEAR writes 0 to address cnt each cycle, cnt = 0..2**ADDR_WIDTH-1, then moves to READY. busy is high for exactly 2**ADDR_WIDTH cycles after rst is released.
  - In READY, busy = 0.
- Requests made while busy are dropped: no write, no dout_valid.
- Accepted request: en_x=1 in READY. Every accepted request, read or write, produces dout_valid_x exactly READY_LATENCY-independent of type, READ_LATENCY cycles later, in order, at full throughput (one per cycle).
- Writes update only the bytes with we_x[i]=1. Written data is visible to any read accepted on the following cycle or later.
- Same-port write: dout_x per RDW_MODE.
  - Write-first: enabled bytes = din, other bytes = old memory.
  - Read-first: old word.
- Cross-port read of an address the other port writes in the same cycle always returns the old word.
- Both ports write the same address in the same cycle:
  - Port A wins on overlapping bytes; non-overlapping bytes from both ports are written.
  - collision pulses for 1 cycle, the cycle after the request.
- dout_x holds its last value when dout_valid_x = 0.
- Address has no wrap logic: the full ADDR_WIDTH range is valid.

Optional Feature:
DPRAM_PARITY_EN
- Defined:
  - Memory stores one even-parity bit per byte, computed from din on write; CLEAR writes parity 0.
  - On read, parity is recomputed. parity_err_x = 1 with dout_valid_x if any byte mismatches.
  - A write-first bypass never reports an error.
- Undefined: no parity storage; parity_err_a/b tied to 0. Ports are present in both builds.

Test Plan:
- Clear: CLEAR_ON_RESET=1, ADDR_WIDTH=4. Release rst → busy high 16 cycles. Read addr 0..15 on A → all 0x00000000, each valid after READ_LATENCY cycles.
- Byte write: A writes 0xDEADBEEF @5 we=1111, then 0x000000AA @5 we=0001. Read on B → 0xDEADBEAA.
- RDW: A writes 0x11223344 @7 over 0xCAFEF00D, we=1111.
  - RDW_MODE=0 → dout_a = 0x11223344.
  - RDW_MODE=1 → dout_a = 0xCAFEF00D.
  - Simultaneous B read @7 → 0xCAFEF00D in both modes.
- Collision: same cycle, A writes 0xAAAAAAAA we=0011 @3, B writes 0xBBBBBBBB we=0110 @3 → mem[3] = 0x00BBAAAA, collision = 1 for one cycle.
- Reset mid-clear: assert rst at clear cycle 6 for 1 cycle → busy stays high; 16 further cycles after release; requests during busy produce no dout_valid.
- Latency sweep: READ_LATENCY=1,2,3, back-to-back reads @0..9 on both ports → dout_valid continuous, data in order, first valid exactly READ_LATENCY cycles after the first request.
